// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage : EX stage of the 5-stage MiniMIPS pipeline.
//   Sits between the ID/EX and EX/MEM registers. It picks the rs and rt
//   operands through the forwarding muxes, chooses SrcB with ALUSrc and the
//   destination register with RegDst. A single-cycle ALU handles
//   AND/OR/ADD/SUB/SLT. MUL runs on an iterative shift-add unit that retires
//   MUL_BPC multiplier bits per cycle and returns the low 32 product bits.
//   While the multiplier runs, StallE freezes IF/ID and ID/EX, and EX/MEM
//   receives bubbles.
//
// Parameters
//   MUL_BPC     multiplier bits per cycle (1,2,4,8); N = 32/MUL_BPC iterations
// Ports
//   CLK, RST              clock (rising edge), async active-low reset
//   RegWriteE..RdE        decoded controls and operands from ID/EX
//   ForwardAE/BE          operand source: 00 RD, 01 ResultW, 10 ALUResultM, 11 RD
//   ALUResultM, ResultW   forwarded values from MEM / WB
//   RegWriteX..WriteRegX  controls, result, store data and dest reg to EX/MEM
//   StallE                1 while a MUL occupies EX (IDLE start cycle + BUSY)
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int MUL_BPC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] SignImmE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ResultW,
  output logic        RegWriteX,
  output logic        MemtoRegX,
  output logic        MemWriteX,
  output logic [31:0] ALUOutX,
  output logic [31:0] WriteDataX,
  output logic [4:0]  WriteRegX,
  output logic        StallE
);

  localparam int N  = 32 / MUL_BPC;
  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_acc, r_mcand, r_mplier;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     w_srca, w_srcb, w_fwdb, w_alu, w_pp;
  logic            w_start, w_stall;

  // ---------------- operand selection ----------------
  always_comb begin
    case (ForwardAE)
      2'b01:   w_srca = ResultW;
      2'b10:   w_srca = ALUResultM;
      default: w_srca = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   w_fwdb = ResultW;
      2'b10:   w_fwdb = ALUResultM;
      default: w_fwdb = RD2_E;
    endcase
  end

  assign w_srcb  = ALUSrcE ? SignImmE : w_fwdb;
  assign w_start = (ALUControlE == OP_MUL);

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    case (ALUControlE)
      OP_AND:  w_alu = w_srca & w_srcb;
      OP_OR:   w_alu = w_srca | w_srcb;
      OP_ADD:  w_alu = w_srca + w_srcb;
      OP_SUB:  w_alu = w_srca - w_srcb;
      OP_SLT:  w_alu = {31'd0, $signed(w_srca) < $signed(w_srcb)};
      default: w_alu = 32'd0;  // reserved codes; MUL result comes from r_acc
    endcase
  end

  // Partial product of the multiplicand and the low MUL_BPC multiplier bits.
  // Only the low 32 bits are kept, matching the truncated product.
  assign w_pp = r_mcand * {{(32-MUL_BPC){1'b0}}, r_mplier[MUL_BPC-1:0]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = BUSY;
      BUSY:    if (r_cnt == CW'(N-1)) w_next = DONE;
      // DONE always returns to IDLE. The MUL still held in ID/EX is not
      // restarted because ID/EX advances at the end of the DONE cycle.
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // RST gates the stall so it drops as soon as reset asserts, even when a MUL
  // is present on ALUControlE while the FSM sits in IDLE.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_start;
      BUSY:    w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign StallE = w_stall & RST;

  // ---------------- multiplier datapath ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          // Latch the operands here. Later forwarding changes have no effect.
          r_mcand  <= w_srca;
          r_mplier <= w_srcb;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        BUSY: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << MUL_BPC;
          r_mplier <= r_mplier >> MUL_BPC;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- EX/MEM outputs ----------------
  assign ALUOutX    = (r_state == DONE) ? r_acc : w_alu;
  assign WriteDataX = w_fwdb;
  assign WriteRegX  = RegDstE ? RdE : RtE;
  assign RegWriteX  = RegWriteE & ~StallE;
  assign MemtoRegX  = MemtoRegE & ~StallE;
  assign MemWriteX  = MemWriteE & ~StallE;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam int NITER = 16;  // 32 / MUL_BPC at the default MUL_BPC=2

  logic        CLK = 0, RST = 0;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, SignImmE, ALUResultM, ResultW;
  logic [4:0]  RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteX, MemtoRegX, MemWriteX, StallE;
  logic [31:0] ALUOutX, WriteDataX;
  logic [4:0]  WriteRegX;

  execute_stage dut (
    .CLK(CLK), .RST(RST),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .RegWriteX(RegWriteX), .MemtoRegX(MemtoRegX), .MemWriteX(MemWriteX),
    .ALUOutX(ALUOutX), .WriteDataX(WriteDataX), .WriteRegX(WriteRegX),
    .StallE(StallE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, m, w;
    logic [1:0]  fa, fb;
    logic        alusrc, regdst, rw, mtr, mw, scr;
    logic [4:0]  rt, rd;
  } instr_t;

  typedef struct {
    logic [31:0] alu, wd;
    logic [4:0]  wreg;
    logic        rw, mtr, mw, is_mul;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   stall_cnt = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rd,
                                      input logic [31:0] m, input logic [31:0] w);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return rd;
  endfunction

  function automatic exp_t model(input instr_t t);
    exp_t e;
    longint unsigned prod;
    logic [31:0] a, b;
    a = fwd(t.fa, t.rd1, t.m, t.w);
    e.wd = fwd(t.fb, t.rd2, t.m, t.w);
    b = t.alusrc ? t.imm : e.wd;
    prod = longint'(a) * longint'(b);
    case (t.op)
      3'd0: e.alu = a & b;
      3'd1: e.alu = a | b;
      3'd2: e.alu = a + b;
      3'd6: e.alu = a - b;
      3'd7: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: e.alu = prod[31:0];
      default: e.alu = 32'd0;
    endcase
    e.wreg = t.regdst ? t.rd : t.rt;
    e.rw = t.rw; e.mtr = t.mtr; e.mw = t.mw;
    e.is_mul = (t.op == 3'd3);
    return e;
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.op = 3'd2; t.rd1 = 0; t.rd2 = 0; t.imm = 0; t.m = 0; t.w = 0;
    t.fa = 0; t.fb = 0; t.alusrc = 0; t.regdst = 0; t.rw = 1; t.mtr = 0; t.mw = 0;
    t.scr = 0; t.rt = 5'd2; t.rd = 5'd3;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd4, 3'd5, 3'd2};
    t = blank();
    t.op  = ($urandom_range(0, 5) == 0) ? 3'd3 : ops[$urandom_range(0, 7)];
    t.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    t.rd2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 10 : $urandom;
    t.imm = $urandom; t.m = $urandom; t.w = $urandom;
    t.fa = 2'($urandom_range(0, 3)); t.fb = 2'($urandom_range(0, 3));
    t.alusrc = 1'($urandom); t.regdst = 1'($urandom);
    t.rw = 1'($urandom); t.mtr = 1'($urandom); t.mw = 1'($urandom);
    t.rt = 5'($urandom); t.rd = 5'($urandom); t.scr = 1;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    ALUControlE = t.op; RD1_E = t.rd1; RD2_E = t.rd2; SignImmE = t.imm;
    ALUResultM = t.m; ResultW = t.w; ForwardAE = t.fa; ForwardBE = t.fb;
    ALUSrcE = t.alusrc; RegDstE = t.regdst; RegWriteE = t.rw;
    MemtoRegE = t.mtr; MemWriteE = t.mw; RtE = t.rt; RdE = t.rd;
  endtask

  // Hold the instruction until EX accepts it. Called just after a posedge,
  // and returns just after the posedge that retires the instruction.
  task automatic issue(input instr_t t);
    int budget;
    drive(t);
    q.push_back(model(t));
    budget = 0;
    forever begin
      @(negedge CLK);
      if (!StallE) break;
      budget++;
      if (budget > 100) begin
        $display("FAIL stall_timeout: stall still high after %0d cycles, expected release", budget);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
      end
      @(posedge CLK); #1;
      if (t.scr) begin
        // Forwarded sources and selects change while the MUL is busy.
        ResultW = $urandom; ALUResultM = $urandom;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      end
    end
    @(posedge CLK); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (!mon_en || !RST) stall_cnt = 0;
    else if (StallE) begin
      stall_cnt++;
      chk("bubble_ctrl", {29'd0, RegWriteX, MemtoRegX, MemWriteX}, 32'd0);
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: ALUOutX %h with empty queue", ALUOutX);
    end else begin
      exp_t e;
      e = q.pop_front();
      chk("ALUOutX", ALUOutX, e.alu);
      chk("ctrl", {29'd0, RegWriteX, MemtoRegX, MemWriteX}, {29'd0, e.rw, e.mtr, e.mw});
      chk("WriteRegX", {27'd0, WriteRegX}, {27'd0, e.wreg});
      if (!e.is_mul) chk("WriteDataX", WriteDataX, e.wd);
      chk("stall_cycles", stall_cnt, e.is_mul ? NITER + 1 : 0);
      stall_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t t;
    t = blank(); t.op = 3'd3; t.rd1 = 5; t.rd2 = 9;
    drive(t);
    RST = 0;
    #12;
    chk("reset_stall", {31'd0, StallE}, 32'd0);
    t = blank(); drive(t);
    @(posedge CLK); #1 RST = 1;
    mon_en = 1;

    // directed: forwarded ADD with immediate
    t = blank(); t.alusrc = 1; t.imm = 3; t.fa = 2'b10; t.m = 7; t.rw = 1; issue(t);
    t.rw = 0; t.mw = 1; issue(t);
    // SUB, SLT, reserved
    t = blank(); t.op = 3'd6; t.rd1 = 3; t.rd2 = 5; issue(t);
    t = blank(); t.op = 3'd7; t.rd1 = 32'hFFFFFFFF; t.rd2 = 1; issue(t);
    t = blank(); t.op = 3'd4; t.rd1 = 32'h1234; t.rd2 = 32'h55; issue(t);
    // MUL with 17 stall cycles
    t = blank(); t.op = 3'd3; t.rd1 = 32'h00010000; t.rd2 = 32'h00010003; t.regdst = 1; issue(t);
    // MUL whose forwarded source changes after the start cycle
    t = blank(); t.op = 3'd3; t.fa = 2'b01; t.w = 6; t.rd2 = 7; t.scr = 1; issue(t);
    // back-to-back MULs
    t = blank(); t.op = 3'd3; t.rd1 = 123456; t.rd2 = 789; issue(t);
    t = blank(); t.op = 3'd3; t.rd1 = 32'hFFFFFFFF; t.rd2 = 32'hFFFFFFFD; issue(t);
    t = blank(); issue(t);

    // random
    for (int i = 0; i < 150; i++) begin
      t = rnd(); issue(t);
    end

    // reset during BUSY
    mon_en = 0;
    q.delete();
    t = blank(); t.op = 3'd3; t.rd1 = 11; t.rd2 = 13; drive(t);
    for (int i = 0; i < 5; i++) begin @(posedge CLK); #1; end
    chk("busy_before_reset", {31'd0, StallE}, 32'd1);
    #2 RST = 0;
    #1 chk("async_reset_stall", {31'd0, StallE}, 32'd0);
    t = blank(); t.rd1 = 100; t.rd2 = 23; t.rw = 1; drive(t);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    chk("post_reset_stall", {31'd0, StallE}, 32'd0);
    chk("post_reset_sum", ALUOutX, 32'd123);
    chk("post_reset_rw", {31'd0, RegWriteX}, 32'd1);
    @(posedge CLK); #1;
    mon_en = 1;
    t = blank(); t.op = 3'd3; t.rd1 = 11; t.rd2 = 13; issue(t);
    t = blank(); t.rd1 = 1; t.rd2 = 2; issue(t);
    mon_en = 0;

    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
